stream_output_arbiter: RTL
==========================

// Module: stream_output_arbiter
// PURPOSE
//  Shares one cross-router output port between N_INPUTS input queues (AXI-Stream beats).
//  - Round-robin arbitration with packet locking: a grant holds until the TLAST beat completes.
//  - Bursts from different inputs never interleave.
//  - Sits between the per-input queues and the output link of each router port.
// PARAMETERS
//  N_INPUTS    5   number of requesting input queues (>=2)
//  DATA_WIDTH  32  TDATA width
//  ID_WIDTH    4   TID width
//  DEST_WIDTH  4   TDEST width
//  USER_WIDTH  4   TUSER width
//  CNT_WIDTH   32  PMU counter width (used only with ARB_PMU_EN)
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    reset, asynchronous, active-low
//  in_tvalid    in   N_INPUTS             per-input valid
//  in_tready    out  N_INPUTS             per-input ready
//  in_tdata     in   N_INPUTS*DATA_WIDTH  flattened, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_tlast     in   N_INPUTS             per-input last
//  in_tid       in   N_INPUTS*ID_WIDTH    flattened TID
//  in_tdest     in   N_INPUTS*DEST_WIDTH  flattened TDEST
//  in_tuser     in   N_INPUTS*USER_WIDTH  flattened TUSER
//  out_tvalid   out  1                    output valid
//  out_tready   in   1                    output ready
//  out_tdata / out_tlast / out_tid / out_tdest / out_tuser  out  widths as above  granted beat
// BEHAVIOUR
//  - FSM states: IDLE, LOCKED.
//    - Registers: state, grant (clog2 N), last_grant.
//    - Reset: state=IDLE, grant=0, last_grant=N_INPUTS-1, so input 0 has first priority.
//  - IDLE: out_tvalid=0, in_tready all 0, out payload don't-care.
//    - If any in_tvalid: pick the first asserted index searching from (last_grant+1) mod N_INPUTS, wrapping.
//    - Register it into grant; next state LOCKED.
//    - No request: stay IDLE.
//  - LOCKED: combinational pass-through of input[grant].
//    - out_tvalid=in_tvalid[grant]; in_tready[grant]=out_tready; all other in_tready=0.
//    - On in_tvalid[grant] && out_tready && in_tlast[grant]: last_grant<=grant; next state IDLE.
//  - Latency: first beat of a packet is visible one cycle after its request.
//    - One bubble cycle between consecutive packets.
//    - Within a packet: zero added latency, full throughput.
//  - Granted input dropping tvalid mid-packet: lock is held; out_tvalid=0 until it resumes.
//  - Single-beat packet (TLAST on first beat): LOCKED for exactly one handshake cycle.
//  - Requests that appear while LOCKED wait; no preemption.
//  - Reset mid-packet: immediate return to IDLE; the partial packet is truncated, with no recovery.
//  - No combinational path from in_tvalid to in_tready.
// CONFIGURATION
//  Macro ARB_PMU_EN. When defined, adds these ports:
//  - pmu_clear       in   1                  synchronous clear of all counters; wins over increment
//  - pmu_grant_cnt   out  N_INPUTS*CNT_WIDTH packets granted per input; +1 on IDLE->LOCKED for grant; saturating
//  - pmu_stall_cnt   out  CNT_WIDTH          cycles in LOCKED with out_tvalid && !out_tready; saturating
//  - All counters reset to 0.
//  When undefined, these ports and counters are absent and behaviour is otherwise identical.
// STRUCTURE
//  - Shared package noc_axis_pkg holds:
//    - arb_state_t enum {IDLE, LOCKED}
//    - axis_beat_t struct (tdata, tlast, tid, tdest, tuser), parameterised by a package localparam
//  - Sub-module rr_pick #(N): combinational rotate-priority picker.
//    - Ports: req[N], last[clog2 N] in; any, idx[clog2 N] out.
//  - Everything else stays in this module.
// TESTING
//  1. Reset, then in_tvalid=5'b00001, 3-beat packet, out_tready=1
//     -> beats on cycles 2..4, in_tready=00001 during lock, IDLE after the TLAST beat.
//  2. All 5 inputs continuously request 1-beat packets
//     -> grant order 0,1,2,3,4,0 with one bubble between packets.
//  3. Input 2 is locked mid-packet; input 4 raises tvalid
//     -> in_tready[4] stays 0 until input 2's TLAST handshake; then grant=4.
//  4. Locked input 1 drops tvalid for 3 cycles mid-packet
//     -> out_tvalid=0 for those cycles, lock held, input 3 not served.
//  5. out_tready held 0 for 4 cycles during lock (ARB_PMU_EN)
//     -> pmu_stall_cnt=4; pmu_grant_cnt[grant]=1; pmu_clear pulse zeroes both.
//  6. rst_n asserted mid-packet
//     -> next cycle out_tvalid=0, in_tready=0, input 0 has first priority.

Source files
------------

// File: rtl/noc_axis_pkg.sv
// noc_axis_pkg: shared arbiter state type and AXI-Stream beat record.
//   arb_state_t  : IDLE (no grant held) / LOCKED (grant held until TLAST handshake)
//   axis_beat_t  : one beat's payload, sized by the AXIS_* localparams
package noc_axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_ID_W   = 4;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_USER_W = 4;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tlast;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_USER_W-1:0] tuser;
  } axis_beat_t;
endpackage

// File: rtl/stream_output_arbiter_if.sv
// stream_output_arbiter_if: N flattened AXI-Stream inputs plus one AXI-Stream output.
//   in_*  : per-input valid/ready/last, payload flattened as input i at [i*W +: W]
//   out_* : the single arbitrated output stream
//   slave modport = arbiter side, master modport = queues/link side
interface stream_output_arbiter_if #(
  parameter int N_INPUTS   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  logic [N_INPUTS-1:0]            in_tvalid;
  logic [N_INPUTS-1:0]            in_tready;
  logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata;
  logic [N_INPUTS-1:0]            in_tlast;
  logic [N_INPUTS*ID_WIDTH-1:0]   in_tid;
  logic [N_INPUTS*DEST_WIDTH-1:0] in_tdest;
  logic [N_INPUTS*USER_WIDTH-1:0] in_tuser;
  logic                           out_tvalid;
  logic                           out_tready;
  logic [DATA_WIDTH-1:0]          out_tdata;
  logic                           out_tlast;
  logic [ID_WIDTH-1:0]            out_tid;
  logic [DEST_WIDTH-1:0]          out_tdest;
  logic [USER_WIDTH-1:0]          out_tuser;
  modport slave (
    input  in_tvalid, in_tdata, in_tlast, in_tid, in_tdest, in_tuser, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest, out_tuser
  );
  modport master (
    output in_tvalid, in_tdata, in_tlast, in_tid, in_tdest, in_tuser, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest, out_tuser
  );
endinterface

// File: rtl/stream_output_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req  : request vector
//   last : previously granted index; search starts at last+1 and wraps
//   any  : at least one request present
//   idx  : first requesting index in rotated order
module rr_pick #(
  parameter int N = 5,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);
  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    any = |req;
    idx = '0;
    for (int o = N; o >= 1; o--)
      if (req[(int'(last) + o) % N]) idx = W'((int'(last) + o) % N);
  end
endmodule

// File: rtl/stream_output_arbiter.sv
// stream_output_arbiter: round-robin, packet-locked share of one AXI-Stream output among N inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_output_arbiter_if.slave (per-input streams in, arbitrated stream out)
//   Optional macro ARB_PMU_EN adds:
//     pmu_clear     : synchronous clear of all counters (wins over increment)
//     pmu_grant_cnt : saturating packets-granted count per input, flattened
//     pmu_stall_cnt : saturating count of LOCKED cycles with out_tvalid && !out_tready
module stream_output_arbiter
  import noc_axis_pkg::*;
#(
  parameter int N_INPUTS   = 5,
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int ID_WIDTH   = AXIS_ID_W,
  parameter int DEST_WIDTH = AXIS_DEST_W,
  parameter int USER_WIDTH = AXIS_USER_W
`ifdef ARB_PMU_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input logic clk,
  input logic rst_n,
  stream_output_arbiter_if.slave bus
`ifdef ARB_PMU_EN
  , input  logic                          pmu_clear,
  output logic [N_INPUTS*CNT_WIDTH-1:0] pmu_grant_cnt,
  output logic [CNT_WIDTH-1:0]          pmu_stall_cnt
`endif
);
  localparam int GW = $clog2(N_INPUTS);
  arb_state_t    state_q;
  logic [GW-1:0] grant_q, last_grant_q, pick_idx;
  logic          pick_any, locked, hs_last;
  axis_beat_t    beat;
  rr_pick #(.N(N_INPUTS)) u_pick (
    .req (bus.in_tvalid),
    .last(last_grant_q),
    .any (pick_any),
    .idx (pick_idx)
  );
  assign locked     = state_q == LOCKED;
  assign beat.tdata = bus.in_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign beat.tlast = bus.in_tlast[grant_q];
  assign beat.tid   = bus.in_tid[grant_q*ID_WIDTH +: ID_WIDTH];
  assign beat.tdest = bus.in_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];
  assign beat.tuser = bus.in_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
  assign bus.out_tvalid = locked && bus.in_tvalid[grant_q];
  assign bus.out_tdata  = beat.tdata;
  assign bus.out_tlast  = beat.tlast;
  assign bus.out_tid    = beat.tid;
  assign bus.out_tdest  = beat.tdest;
  assign bus.out_tuser  = beat.tuser;
  // Ready depends only on state and out_tready, never on in_tvalid.
  assign bus.in_tready  = (locked && bus.out_tready) ? N_INPUTS'(1) << grant_q : '0;
  assign hs_last        = bus.out_tvalid && bus.out_tready && beat.tlast;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_INPUTS - 1);
    end else if (!locked) begin
      if (pick_any) begin
        grant_q <= pick_idx;
        state_q <= LOCKED;
      end
    end else if (hs_last) begin
      last_grant_q <= grant_q;
      state_q      <= IDLE;
    end
`ifdef ARB_PMU_EN
  logic [CNT_WIDTH-1:0] grant_cnt_q [N_INPUTS];
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) grant_cnt_q[i] <= '0;
    end else if (pmu_clear) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) grant_cnt_q[i] <= '0;
    end else begin
      if (bus.out_tvalid && !bus.out_tready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (!locked && pick_any && grant_cnt_q[pick_idx] != '1)
        grant_cnt_q[pick_idx] <= grant_cnt_q[pick_idx] + CNT_WIDTH'(1);
    end
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_cnt
    assign pmu_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = grant_cnt_q[g];
  end
  assign pmu_stall_cnt = stall_cnt_q;
`endif
endmodule
